bank_biu_linefill_rd: RTL and testbench
=======================================

Name: bank_biu_linefill_rd

Overview:
- Read-side bus interface for one cache bank.
- Accepts linefill requests from the hit-test unit and issues one AXI read burst per request: 2 beats of 128 bits, ARID = {set, way}.
- Assembles the two R beats into a 256-bit line and delivers it to the ISU on the biu_isu_r* interface. This block drives that interface's valid, data and id; the ISU drives its ready.
- Bounds outstanding bursts and applies backpressure on both sides.

Parameters:
- REQ_FIFO_DEPTH, 4, entries in the linefill request FIFO (power of 2, >=2).
- MAX_OUTSTANDING, 8, maximum AR bursts issued whose last beat has not yet been accepted (<=64).
- ADDR_WIDTH, 32, AXI address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- htu_biu_req_valid_i  in  1  linefill request valid.
- htu_biu_req_ready_o  out  1  request accepted when valid & ready.
- htu_biu_req_addr_i  in  ADDR_WIDTH  line address; bits [4:0] ignored.
- htu_biu_req_set_i  in  3  set index.
- htu_biu_req_way_i  in  3  way index.
- biu_mem_arvalid_o  out  1  AR valid.
- biu_mem_arready_i  in  1  AR ready.
- biu_mem_araddr_o  out  ADDR_WIDTH  {addr[ADDR_WIDTH-1:5], 5'b0}.
- biu_mem_arid_o  out  6  {set, way}.
- biu_mem_arlen_o  out  8  constant 8'd1.
- biu_mem_arsize_o  out  3  constant 3'd4.
- biu_mem_arburst_o  out  2  constant 2'b01 (INCR).
- mem_biu_rvalid_i  in  1  R valid.
- mem_biu_rready_o  out  1  R ready.
- mem_biu_rdata_i  in  128  R data beat.
- mem_biu_rid_i  in  6  R id.
- mem_biu_rlast_i  in  1  R last.
- mem_biu_rresp_i  in  2  R response.
- biu_isu_rvalid_o  out  1  assembled line valid.
- biu_isu_rready_i  in  1  ISU ready.
- biu_isu_rdata_o  out  256  assembled line.
- biu_isu_rid_o  out  6  {set, way} of the line.
- biu_outstanding_o  out  7  current outstanding count.

Behaviour:
Reset:
- All valid outputs 0.
- FIFO empty, so htu_biu_req_ready_o=1 immediately after reset.
- Outstanding count 0; assembly FSM in R_BEAT0.
- biu_isu_rdata_o and biu_isu_rid_o 0.
- Reset mid-burst discards all partial state; there is no recovery of in-flight bursts.

Request FIFO:
- htu_biu_req_ready_o = ~full. No bypass: a push and pop in the same cycle while full is impossible because ready is 0.
- Push and pop in the same cycle while non-full both take effect.
- Pointers wrap modulo REQ_FIFO_DEPTH.

AR issue:
- biu_mem_arvalid_o = ~fifo_empty & (outstanding < MAX_OUTSTANDING).
- The head entry drives the AR fields combinationally. It is popped on arvalid & arready.
- Once arvalid is asserted, the head cannot change until the handshake completes, so AR is stable (AXI rule).
- Earliest AR: the cycle after the request handshake.

Outstanding counter:
- +1 on an AR handshake.
- -1 on acceptance of a beat with rlast=1.
- Both in the same cycle: unchanged.
- At MAX_OUTSTANDING, arvalid is forced low (including when the FIFO is non-empty).

Assembly FSM:
- R_BEAT0: mem_biu_rready_o=1. On rvalid, store rdata into line[127:0] and rid into the id register, then go to R_BEAT1.
- R_BEAT1: mem_biu_rready_o=1. On rvalid, store rdata into line[255:128], then go to R_OUT. The outstanding count decrements on this beat (rlast=1).
- R_OUT: biu_isu_rvalid_o=1; data and id held stable; mem_biu_rready_o = biu_isu_rready_i.
  - On ISU handshake only: go to R_BEAT0.
  - On ISU handshake plus an R beat in the same cycle: capture that beat as beat0 and go to R_BEAT1.
- Latency: beat1 accepted at edge N gives biu_isu_rvalid_o=1 in the cycle after N.
- With biu_isu_rready_i tied 1, sustained throughput is one line per 2 cycles.

Memory-side protocol guarantees:
- Memory returns the beats of one ID contiguously (no interleave).
- rlast=1 only on beat1.
- rresp is ignored unless the optional feature is enabled.

Optional Feature:
- Macro: BIU_RRESP_CHECK_EN.
- Enabled, adds two ports:
  - biu_rresp_err_o  out  1: sticky flag, set when an accepted beat has rresp != 2'b00; cleared only by reset.
  - biu_rresp_err_id_o  out  6: rid of the first erroring beat.
  - Data delivery is unchanged in either case.
- Disabled: these ports do not exist and rresp is unused.

Decomposition:
- Shared package bank_biu_pkg holds:
  - ARLEN_LINE=8'd1, ARSIZE_16B=3'd4, BURST_INCR=2'b01.
  - LINE_BEATS=2, BEAT_W=128, LINE_W=256.
  - A typedef for the request FIFO entry {addr, set, way}.
  - The FSM state enum {R_BEAT0, R_BEAT1, R_OUT}.
- One sub-module, bank_biu_req_fifo: a generic synchronous FIFO parameterised by width and depth, with full/empty outputs.

Test Plan:
- Single request: addr=0x0000_1234, set=5, way=2.
  - Expect AR with araddr=0x0000_1220, arid=6'o52, arlen=1.
  - Return beats 0xA..A then 0xB..B.
  - Expect biu_isu_rdata_o={0xB..B, 0xA..A}, rid=6'h2A, rvalid one cycle after beat1.
- FIFO full: arready held 0, push 4 requests.
  - htu_biu_req_ready_o drops to 0 after the 4th push.
  - Raise arready; exactly 4 ARs issue in order and ready returns to 1.
- Outstanding limit: 10 requests pushed, no R data returned.
  - Exactly 8 ARs issue and biu_outstanding_o=8.
  - Complete one line: a 9th AR issues only after that line's beat1 is accepted.
- ISU backpressure: biu_isu_rready_i=0 for 5 cycles with a second burst pending on R.
  - mem_biu_rready_o=0 throughout; line1 data and id stable.
  - On the rready pulse, line1 handshakes and beat0 of line2 is captured in the same cycle.
- Back-to-back: rready_i=1, 4 bursts streamed continuously.
  - 4 lines delivered, one every 2 cycles, with correct rids.
  - Outstanding returns to 0.
- Reset mid-burst: assert rst_i after beat0.
  - All valids 0, FSM in R_BEAT0, outstanding 0, req_ready 1.
  - With BIU_RRESP_CHECK_EN: rresp=2'b10 on beat1 of rid 0x11 sets err=1 and err_id=0x11, and both persist until reset.

Source files
------------

// File: rtl/bank_biu_pkg.sv
// Shared constants and types for the cache-bank read-side bus interface.
package bank_biu_pkg;

  localparam logic [7:0] ARLEN_LINE = 8'd1;
  localparam logic [2:0] ARSIZE_16B = 3'd4;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam int LINE_BEATS = 2;
  localparam int BEAT_W     = 128;
  localparam int LINE_W     = 256;
  localparam int ID_W       = 6;

  // Widest address the request entry can carry; the top truncates to ADDR_WIDTH.
  localparam int REQ_ADDR_W = 64;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [2:0]            set;
    logic [2:0]            way;
  } req_entry_t;

  typedef enum logic [1:0] {
    R_BEAT0,
    R_BEAT1,
    R_OUT
  } r_state_e;

endpackage

// File: rtl/bank_biu_linefill_rd_if.sv
// Bus bundle for bank_biu_linefill_rd: HTU request, AXI AR/R and ISU line delivery.
// Optional rresp error ports exist only when BIU_RRESP_CHECK_EN is defined.
interface bank_biu_linefill_rd_if
  import bank_biu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
);

  logic                  htu_biu_req_valid_i;
  logic                  htu_biu_req_ready_o;
  logic [ADDR_WIDTH-1:0] htu_biu_req_addr_i;
  logic [2:0]            htu_biu_req_set_i;
  logic [2:0]            htu_biu_req_way_i;

  logic                  biu_mem_arvalid_o;
  logic                  biu_mem_arready_i;
  logic [ADDR_WIDTH-1:0] biu_mem_araddr_o;
  logic [ID_W-1:0]       biu_mem_arid_o;
  logic [7:0]            biu_mem_arlen_o;
  logic [2:0]            biu_mem_arsize_o;
  logic [1:0]            biu_mem_arburst_o;

  logic                  mem_biu_rvalid_i;
  logic                  mem_biu_rready_o;
  logic [BEAT_W-1:0]     mem_biu_rdata_i;
  logic [ID_W-1:0]       mem_biu_rid_i;
  logic                  mem_biu_rlast_i;
  logic [1:0]            mem_biu_rresp_i;

  logic                  biu_isu_rvalid_o;
  logic                  biu_isu_rready_i;
  logic [LINE_W-1:0]     biu_isu_rdata_o;
  logic [ID_W-1:0]       biu_isu_rid_o;
  logic [6:0]            biu_outstanding_o;
`ifdef BIU_RRESP_CHECK_EN
  logic                  biu_rresp_err_o;
  logic [ID_W-1:0]       biu_rresp_err_id_o;
`endif

  modport slave (
    input  htu_biu_req_valid_i, htu_biu_req_addr_i, htu_biu_req_set_i, htu_biu_req_way_i,
    output htu_biu_req_ready_o,
    output biu_mem_arvalid_o, biu_mem_araddr_o, biu_mem_arid_o, biu_mem_arlen_o,
    output biu_mem_arsize_o, biu_mem_arburst_o,
    input  biu_mem_arready_i,
    input  mem_biu_rvalid_i, mem_biu_rdata_i, mem_biu_rid_i, mem_biu_rlast_i, mem_biu_rresp_i,
    output mem_biu_rready_o,
    output biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o, biu_outstanding_o,
    input  biu_isu_rready_i
`ifdef BIU_RRESP_CHECK_EN
    , output biu_rresp_err_o, biu_rresp_err_id_o
`endif
  );

  modport master (
    output htu_biu_req_valid_i, htu_biu_req_addr_i, htu_biu_req_set_i, htu_biu_req_way_i,
    input  htu_biu_req_ready_o,
    input  biu_mem_arvalid_o, biu_mem_araddr_o, biu_mem_arid_o, biu_mem_arlen_o,
    input  biu_mem_arsize_o, biu_mem_arburst_o,
    output biu_mem_arready_i,
    output mem_biu_rvalid_i, mem_biu_rdata_i, mem_biu_rid_i, mem_biu_rlast_i, mem_biu_rresp_i,
    input  mem_biu_rready_o,
    input  biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o, biu_outstanding_o,
    output biu_isu_rready_i
`ifdef BIU_RRESP_CHECK_EN
    , input biu_rresp_err_o, biu_rresp_err_id_o
`endif
  );

endinterface

// File: rtl/bank_biu_req_fifo.sv
// Generic synchronous FIFO with full/empty flags; DEPTH must be a power of 2.
module bank_biu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);

endmodule

// File: rtl/bank_biu_linefill_rd.sv
// Cache-bank linefill read path: queues HTU requests, issues 2-beat AXI bursts, assembles lines for the ISU.
// Define BIU_RRESP_CHECK_EN to add the sticky rresp error flag and first-error id outputs.
module bank_biu_linefill_rd
  import bank_biu_pkg::*;
#(
  parameter int REQ_FIFO_DEPTH  = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_WIDTH      = 32
) (
  input logic                   clk_i,
  input logic                   rst_i,
  bank_biu_linefill_rd_if.slave bus
);

  localparam logic [6:0] MAX_OUT = 7'(MAX_OUTSTANDING);

  req_entry_t        w_push_entry;
  req_entry_t        w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_arvalid;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_last_hs;
  logic              w_rready;
  logic              w_isu_rvalid;
  logic              w_cap_beat0;
  logic              w_cap_beat1;
  r_state_e          r_state;
  r_state_e          w_state_nxt;
  logic [6:0]        r_outstanding;
  logic [LINE_W-1:0] r_line;
  logic [ID_W-1:0]   r_id;

  always_comb begin
    w_push_entry.addr = REQ_ADDR_W'(bus.htu_biu_req_addr_i);
    w_push_entry.set  = bus.htu_biu_req_set_i;
    w_push_entry.way  = bus.htu_biu_req_way_i;
  end

  assign w_push = bus.htu_biu_req_valid_i && !w_fifo_full;

  bank_biu_req_fifo #(
    .WIDTH ($bits(req_entry_t)),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_ar_hs),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // AR is driven straight from the FIFO head, so it stays stable until popped.
  assign w_arvalid = !w_fifo_empty && (r_outstanding < MAX_OUT);
  assign w_ar_hs   = w_arvalid && bus.biu_mem_arready_i;
  assign w_r_hs    = bus.mem_biu_rvalid_i && w_rready;
  assign w_last_hs = w_r_hs && bus.mem_biu_rlast_i;

  assign bus.htu_biu_req_ready_o = !w_fifo_full;
  assign bus.biu_mem_arvalid_o   = w_arvalid;
  assign bus.biu_mem_araddr_o    = {w_head.addr[ADDR_WIDTH-1:5], 5'b0};
  assign bus.biu_mem_arid_o      = {w_head.set, w_head.way};
  assign bus.biu_mem_arlen_o     = ARLEN_LINE;
  assign bus.biu_mem_arsize_o    = ARSIZE_16B;
  assign bus.biu_mem_arburst_o   = BURST_INCR;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else begin
      case ({w_ar_hs, w_last_hs})
        2'b10:   r_outstanding <= r_outstanding + 7'd1;
        2'b01:   r_outstanding <= r_outstanding - 7'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= R_BEAT0;
    else       r_state <= w_state_nxt;
  end

  // In R_OUT the R channel only opens when the ISU takes the line, letting beat0 of the next line overlap.
  always_comb begin
    w_state_nxt  = r_state;
    w_rready     = 1'b1;
    w_isu_rvalid = 1'b0;
    w_cap_beat0  = 1'b0;
    w_cap_beat1  = 1'b0;
    unique case (r_state)
      R_BEAT0: begin
        if (bus.mem_biu_rvalid_i) begin
          w_cap_beat0 = 1'b1;
          w_state_nxt = R_BEAT1;
        end
      end
      R_BEAT1: begin
        if (bus.mem_biu_rvalid_i) begin
          w_cap_beat1 = 1'b1;
          w_state_nxt = R_OUT;
        end
      end
      R_OUT: begin
        w_isu_rvalid = 1'b1;
        w_rready     = bus.biu_isu_rready_i;
        if (bus.biu_isu_rready_i) begin
          if (bus.mem_biu_rvalid_i) begin
            w_cap_beat0 = 1'b1;
            w_state_nxt = R_BEAT1;
          end else begin
            w_state_nxt = R_BEAT0;
          end
        end
      end
      default: w_state_nxt = R_BEAT0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_line <= '0;
      r_id   <= '0;
    end else begin
      if (w_cap_beat0) begin
        r_line[BEAT_W-1:0] <= bus.mem_biu_rdata_i;
        r_id               <= bus.mem_biu_rid_i;
      end
      if (w_cap_beat1) r_line[LINE_W-1:BEAT_W] <= bus.mem_biu_rdata_i;
    end
  end

  assign bus.mem_biu_rready_o  = w_rready;
  assign bus.biu_isu_rvalid_o  = w_isu_rvalid;
  assign bus.biu_isu_rdata_o   = r_line;
  assign bus.biu_isu_rid_o     = r_id;
  assign bus.biu_outstanding_o = r_outstanding;

  logic w_unused;
`ifdef BIU_RRESP_CHECK_EN
  logic            r_err;
  logic [ID_W-1:0] r_err_id;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err    <= 1'b0;
      r_err_id <= '0;
    end else if (w_r_hs && (bus.mem_biu_rresp_i != 2'b00) && !r_err) begin
      r_err    <= 1'b1;
      r_err_id <= bus.mem_biu_rid_i;
    end
  end

  assign bus.biu_rresp_err_o    = r_err;
  assign bus.biu_rresp_err_id_o = r_err_id;
  assign w_unused = ^{w_head.addr[REQ_ADDR_W-1:ADDR_WIDTH], w_head.addr[4:0]};
`else
  assign w_unused = ^{w_head.addr[REQ_ADDR_W-1:ADDR_WIDTH], w_head.addr[4:0], bus.mem_biu_rresp_i};
`endif

endmodule

// File: tb/tb_bank_biu_linefill_rd.sv
// Randomised bench for bank_biu_linefill_rd with a queue-based reference model and directed scenarios.
`timescale 1ns/1ps
module tb_bank_biu_linefill_rd;
  import bank_biu_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bank_biu_linefill_rd_if #(.ADDR_WIDTH(AW)) bus ();

  bank_biu_linefill_rd #(
    .REQ_FIFO_DEPTH (DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct { logic [AW-1:0] addr; logic [5:0] id; } req_t;
  typedef struct { logic [5:0] id; logic [127:0] b0; logic [127:0] b1; logic bad1; } burst_t;
  typedef struct { logic [255:0] data; logic [5:0] id; } line_t;

  // Reference model: pending requests, accepted bursts awaiting data, finished lines awaiting the ISU.
  req_t   to_push[$];
  req_t   req_q[$];
  burst_t mq[$];
  line_t  lines[$];
  int     outst;
  int     beat;
  logic   m_err;
  logic [5:0] m_err_id;

  int total, bad;
  int p_ar, p_r, p_isu;
  logic fixed_en;
  logic [127:0] fix_b0, fix_b1;
  logic bad_en;
  logic [5:0] bad_id;
  logic last_hr;
  int ar_seen;
  int cyc;
  int isu_cycles[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic to_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.addr = $urandom;
    r.id   = 6'($urandom_range(0, 63));
    return r;
  endfunction

  task automatic zero_inputs();
    bus.htu_biu_req_valid_i = 1'b0;
    bus.htu_biu_req_addr_i  = '0;
    bus.htu_biu_req_set_i   = '0;
    bus.htu_biu_req_way_i   = '0;
    bus.biu_mem_arready_i   = 1'b0;
    bus.mem_biu_rvalid_i    = 1'b0;
    bus.mem_biu_rdata_i     = '0;
    bus.mem_biu_rid_i       = '0;
    bus.mem_biu_rlast_i     = 1'b0;
    bus.mem_biu_rresp_i     = 2'b00;
    bus.biu_isu_rready_i    = 1'b0;
    last_hr = 1'b0;
  endtask

  task automatic drive();
    logic rv;
    bus.htu_biu_req_valid_i = (to_push.size() > 0);
    if (to_push.size() > 0) begin
      bus.htu_biu_req_addr_i = to_push[0].addr;
      bus.htu_biu_req_set_i  = to_push[0].id[5:3];
      bus.htu_biu_req_way_i  = to_push[0].id[2:0];
    end
    bus.biu_mem_arready_i = ($urandom_range(0, 99) < p_ar);
    // A presented beat stays valid until it is taken.
    rv = (mq.size() > 0) &&
         ((bus.mem_biu_rvalid_i && !last_hr) || ($urandom_range(0, 99) < p_r));
    bus.mem_biu_rvalid_i = rv;
    if (rv) begin
      bus.mem_biu_rdata_i = (beat == 1) ? mq[0].b1 : mq[0].b0;
      bus.mem_biu_rid_i   = mq[0].id;
      bus.mem_biu_rlast_i = (beat == 1);
      bus.mem_biu_rresp_i = (beat == 1 && mq[0].bad1) ? 2'b10 : 2'b00;
    end else begin
      bus.mem_biu_rdata_i = '0;
      bus.mem_biu_rid_i   = '0;
      bus.mem_biu_rlast_i = 1'b0;
      bus.mem_biu_rresp_i = 2'b00;
    end
    bus.biu_isu_rready_i = ($urandom_range(0, 99) < p_isu);
  endtask

  // One clock: compare at negedge, advance the model at posedge, drive new inputs just after.
  task automatic cycle();
    logic e_rq, e_arv, e_rr, e_iv;
    logic h_req, h_ar, h_r, h_isu, h_ar_dut, h_isu_dut;
    burst_t b;
    line_t  l;
    @(negedge clk);
    e_rq  = (req_q.size() < DEPTH);
    e_arv = (req_q.size() > 0) && (outst < MAXO);
    e_iv  = (lines.size() > 0);
    e_rr  = e_iv ? bus.biu_isu_rready_i : 1'b1;
    chk("req_ready", 256'(bus.htu_biu_req_ready_o), 256'(e_rq));
    chk("arvalid", 256'(bus.biu_mem_arvalid_o), 256'(e_arv));
    if (e_arv) begin
      chk("araddr", 256'(bus.biu_mem_araddr_o), 256'({req_q[0].addr[AW-1:5], 5'b0}));
      chk("arid", 256'(bus.biu_mem_arid_o), 256'(req_q[0].id));
      chk("arlen", 256'(bus.biu_mem_arlen_o), 256'(8'd1));
      chk("arsize", 256'(bus.biu_mem_arsize_o), 256'(3'd4));
      chk("arburst", 256'(bus.biu_mem_arburst_o), 256'(2'b01));
    end
    chk("mem_rready", 256'(bus.mem_biu_rready_o), 256'(e_rr));
    chk("isu_rvalid", 256'(bus.biu_isu_rvalid_o), 256'(e_iv));
    if (e_iv) begin
      chk("isu_rdata", bus.biu_isu_rdata_o, lines[0].data);
      chk("isu_rid", 256'(bus.biu_isu_rid_o), 256'(lines[0].id));
    end
    chk("outstanding", 256'(bus.biu_outstanding_o), 256'(outst));
`ifdef BIU_RRESP_CHECK_EN
    chk("rresp_err", 256'(bus.biu_rresp_err_o), 256'(m_err));
    if (m_err) chk("rresp_err_id", 256'(bus.biu_rresp_err_id_o), 256'(m_err_id));
`endif
    h_req     = bus.htu_biu_req_valid_i && e_rq;
    h_ar      = e_arv && bus.biu_mem_arready_i;
    h_r       = bus.mem_biu_rvalid_i && e_rr;
    h_isu     = e_iv && bus.biu_isu_rready_i;
    h_ar_dut  = bus.biu_mem_arvalid_o && bus.biu_mem_arready_i;
    h_isu_dut = bus.biu_isu_rvalid_o && bus.biu_isu_rready_i;
    @(posedge clk);
    cyc++;
    if (h_ar_dut) ar_seen++;
    if (h_isu_dut) isu_cycles.push_back(cyc);
    if (h_isu) void'(lines.pop_front());
    if (h_r) begin
      if (bus.mem_biu_rresp_i != 2'b00 && !m_err) begin
        m_err    = 1'b1;
        m_err_id = mq[0].id;
      end
      if (beat == 0) begin
        beat = 1;
      end else begin
        l.data = {mq[0].b1, mq[0].b0};
        l.id   = mq[0].id;
        lines.push_back(l);
        void'(mq.pop_front());
        beat = 0;
        outst--;
      end
    end
    if (h_ar) begin
      b.id   = req_q[0].id;
      b.b0   = fixed_en ? fix_b0 : {$urandom, $urandom, $urandom, $urandom};
      b.b1   = fixed_en ? fix_b1 : {$urandom, $urandom, $urandom, $urandom};
      b.bad1 = bad_en && (req_q[0].id == bad_id);
      mq.push_back(b);
      void'(req_q.pop_front());
      outst++;
    end
    if (h_req) begin
      req_q.push_back(to_push[0]);
      void'(to_push.pop_front());
    end
    last_hr = h_r;
    #1;
    drive();
  endtask

  task automatic drain(input string name);
    int n;
    p_ar = 100; p_r = 100; p_isu = 100;
    drive();
    n = 0;
    while ((to_push.size() + req_q.size() + mq.size() + lines.size()) > 0 && n < 300) begin
      cycle();
      n++;
    end
    if ((to_push.size() + req_q.size() + mq.size() + lines.size()) > 0) to_fail(name);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0;
    req_t r;
    logic [255:0] d1;
    logic [5:0] i1;
    total = 0; bad = 0;
    outst = 0; beat = 0; m_err = 1'b0; m_err_id = '0;
    p_ar = 0; p_r = 0; p_isu = 0;
    fixed_en = 1'b0; fix_b0 = '0; fix_b1 = '0;
    bad_en = 1'b0; bad_id = '0;
    ar_seen = 0; cyc = 0;
    zero_inputs();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 256'(bus.htu_biu_req_ready_o), 256'(1'b1));
    chk("rst_arvalid", 256'(bus.biu_mem_arvalid_o), 256'(1'b0));
    chk("rst_isu_rvalid", 256'(bus.biu_isu_rvalid_o), 256'(1'b0));
    chk("rst_outstanding", 256'(bus.biu_outstanding_o), 256'(7'd0));
    chk("rst_rdata", bus.biu_isu_rdata_o, 256'd0);
    chk("rst_rid", 256'(bus.biu_isu_rid_o), 256'(6'd0));
    chk("rst_mem_rready", 256'(bus.mem_biu_rready_o), 256'(1'b1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();

    // Single request with known beats.
    fixed_en = 1'b1;
    fix_b0 = {32{4'hA}};
    fix_b1 = {32{4'hB}};
    p_ar = 100; p_r = 100; p_isu = 100;
    r.addr = 32'h0000_1234; r.id = {3'd5, 3'd2};
    to_push.push_back(r);
    drive();
    cycle();
    chk("t1_arvalid", 256'(bus.biu_mem_arvalid_o), 256'(1'b1));
    chk("t1_araddr", 256'(bus.biu_mem_araddr_o), 256'(32'h0000_1220));
    chk("t1_arid", 256'(bus.biu_mem_arid_o), 256'(6'o52));
    chk("t1_arlen", 256'(bus.biu_mem_arlen_o), 256'(8'd1));
    n = 0;
    while (!bus.biu_isu_rvalid_o && n < 20) begin cycle(); n++; end
    if (!bus.biu_isu_rvalid_o) to_fail("t1_line");
    else begin
      chk("t1_rdata", bus.biu_isu_rdata_o, {{32{4'hB}}, {32{4'hA}}});
      chk("t1_rid", 256'(bus.biu_isu_rid_o), 256'(6'h2A));
      if (lines.size() > 0) chk("t1_model_line", lines[0].data, {{32{4'hB}}, {32{4'hA}}});
      else to_fail("t1_model_line");
    end
    drain("t1_drain");
    fixed_en = 1'b0;

    // FIFO fills while AR is blocked.
    p_ar = 0; p_r = 100; p_isu = 100;
    for (int i = 0; i < 4; i++) to_push.push_back(rand_req());
    drive();
    n = 0;
    while (to_push.size() > 0 && n < 20) begin cycle(); n++; end
    if (to_push.size() > 0) to_fail("t2_push");
    chk("t2_full_ready", 256'(bus.htu_biu_req_ready_o), 256'(1'b0));
    a0 = ar_seen;
    p_ar = 100;
    drive();
    n = 0;
    while ((ar_seen - a0) < 4 && n < 20) begin cycle(); n++; end
    chk("t2_ar_count", 256'(ar_seen - a0), 256'(4));
    chk("t2_ready_back", 256'(bus.htu_biu_req_ready_o), 256'(1'b1));
    drain("t2_drain");

    // Outstanding limit with no read data returning.
    p_ar = 100; p_r = 0; p_isu = 100;
    a0 = ar_seen;
    for (int i = 0; i < 10; i++) to_push.push_back(rand_req());
    drive();
    repeat (40) cycle();
    chk("t3_outstanding", 256'(bus.biu_outstanding_o), 256'(7'd8));
    chk("t3_ar_count", 256'(ar_seen - a0), 256'(8));
    p_r = 100;
    drive();
    n = 0;
    while ((ar_seen - a0) < 9 && n < 20) begin cycle(); n++; end
    chk("t3_ninth_ar", 256'(ar_seen - a0), 256'(9));
    drain("t3_drain");

    // ISU backpressure with the next burst waiting on R.
    p_ar = 100; p_r = 100; p_isu = 0;
    for (int i = 0; i < 2; i++) to_push.push_back(rand_req());
    drive();
    n = 0;
    while (!bus.biu_isu_rvalid_o && n < 20) begin cycle(); n++; end
    if (!bus.biu_isu_rvalid_o) to_fail("t4_line1");
    d1 = bus.biu_isu_rdata_o;
    i1 = bus.biu_isu_rid_o;
    repeat (5) begin
      cycle();
      chk("t4_rready_low", 256'(bus.mem_biu_rready_o), 256'(1'b0));
      chk("t4_data_stable", bus.biu_isu_rdata_o, d1);
      chk("t4_id_stable", 256'(bus.biu_isu_rid_o), 256'(i1));
    end
    p_isu = 100;
    drive();
    cycle();
    chk("t4_after_isu_rvalid", 256'(bus.biu_isu_rvalid_o), 256'(1'b0));
    chk("t4_after_isu_rready", 256'(bus.mem_biu_rready_o), 256'(1'b1));
    chk("t4_after_isu_outst", 256'(bus.biu_outstanding_o), 256'(7'd1));
    drain("t4_drain");

    // Back-to-back streaming.
    p_ar = 100; p_r = 0; p_isu = 100;
    a0 = ar_seen;
    for (int i = 0; i < 4; i++) to_push.push_back(rand_req());
    drive();
    n = 0;
    while ((ar_seen - a0) < 4 && n < 20) begin cycle(); n++; end
    isu_cycles.delete();
    p_r = 100;
    drive();
    n = 0;
    while (isu_cycles.size() < 4 && n < 30) begin cycle(); n++; end
    chk("t5_lines", 256'(isu_cycles.size()), 256'(4));
    for (int i = 1; i < isu_cycles.size(); i++)
      chk("t5_spacing", 256'(isu_cycles[i] - isu_cycles[i-1]), 256'(2));
    chk("t5_outst_zero", 256'(bus.biu_outstanding_o), 256'(7'd0));
    drain("t5_drain");

    // Randomised traffic.
    for (int seg = 0; seg < 10; seg++) begin
      p_ar  = $urandom_range(20, 100);
      p_r   = $urandom_range(20, 100);
      p_isu = $urandom_range(10, 100);
      repeat (200) begin
        if (to_push.size() == 0 && $urandom_range(0, 99) < 50) begin
          to_push.push_back(rand_req());
          drive();
        end
        cycle();
      end
    end
    drain("rand_drain");

`ifdef BIU_RRESP_CHECK_EN
    // Error response on beat1 of id 0x11 latches a sticky flag.
    bad_en = 1'b1; bad_id = 6'h11;
    r.addr = $urandom; r.id = 6'h11;
    to_push.push_back(r);
    drive();
    drain("t7_err_drain");
    bad_en = 1'b0;
    chk("t7_err", 256'(bus.biu_rresp_err_o), 256'(1'b1));
    chk("t7_err_id", 256'(bus.biu_rresp_err_id_o), 256'(6'h11));
    r.addr = $urandom; r.id = 6'h22;
    to_push.push_back(r);
    drive();
    drain("t7_clean_drain");
    chk("t7_err_sticky", 256'(bus.biu_rresp_err_o), 256'(1'b1));
    chk("t7_err_id_sticky", 256'(bus.biu_rresp_err_id_o), 256'(6'h11));
`endif

    // Reset in the middle of a burst.
    p_ar = 100; p_r = 100; p_isu = 100;
    to_push.push_back(rand_req());
    drive();
    n = 0;
    while (beat != 1 && n < 20) begin cycle(); n++; end
    if (beat != 1) to_fail("t6_beat0");
    rst = 1'b1;
    zero_inputs();
    #1;
    chk("t6_arvalid", 256'(bus.biu_mem_arvalid_o), 256'(1'b0));
    chk("t6_isu_rvalid", 256'(bus.biu_isu_rvalid_o), 256'(1'b0));
    chk("t6_outstanding", 256'(bus.biu_outstanding_o), 256'(7'd0));
    chk("t6_req_ready", 256'(bus.htu_biu_req_ready_o), 256'(1'b1));
    chk("t6_mem_rready", 256'(bus.mem_biu_rready_o), 256'(1'b1));
    chk("t6_rdata", bus.biu_isu_rdata_o, 256'd0);
`ifdef BIU_RRESP_CHECK_EN
    chk("t6_err_cleared", 256'(bus.biu_rresp_err_o), 256'(1'b0));
`endif
    to_push.delete(); req_q.delete(); mq.delete(); lines.delete();
    outst = 0; beat = 0; m_err = 1'b0; m_err_id = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    repeat (3) cycle();
    to_push.push_back(rand_req());
    drive();
    drain("t6_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
